calculadora_arbitro: RTL and testbench

- Shares one `calculadora` instance (8-bit operands `a`/`b`, 2-bit `modo`, result `c`, enable `enb`) between two requesters.
- Round-robin arbitration; latches the winner's operands and issues a one-cycle `enb` to the calculator.
- Waits a fixed latency, captures `c` and returns it to the granted requester with a one-cycle done pulse.
- Sits between the two client blocks and the calculator datapath.

---
 rtl/calculadora_pkg.sv | 18 +
 rtl/arbitro_rr.sv | 16 +
 rtl/calculadora_arbitro.sv | 111 +++++++++++
 tb/tb_calculadora_arbitro.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calculadora_pkg.sv
// Shared types and constants for the two-requester calculator arbiter.
package calculadora_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        EMITIR  = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    localparam int ANCHO_DEF = 8;

    localparam logic [1:0] MODO_SUMA  = 2'b00;
    localparam logic [1:0] MODO_RESTA = 2'b01;
    localparam logic [1:0] MODO_AND   = 2'b10;
    localparam logic [1:0] MODO_OR    = 2'b11;

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin grant: on a tie the requester that did not win last time goes.
module arbitro_rr (
    input  logic req0,
    input  logic req1,
    input  logic ultimo,
    output logic gnt_valid,
    output logic gnt_sel
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) gnt_sel = ~ultimo;
        else              gnt_sel = req1;
    end

endmodule

// File: rtl/calculadora_arbitro.sv
// Shares one calculator between two requesters: grant, issue one enb, wait a
// fixed latency, capture c and hand it back with a one-cycle listo pulse.
module calculadora_arbitro
    import calculadora_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int LATENCIA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       modo0,
    input  logic [ANCHO-1:0] a0,
    input  logic [ANCHO-1:0] b0,
    output logic             listo0,
    output logic [ANCHO-1:0] res0,
    input  logic             req1,
    input  logic [1:0]       modo1,
    input  logic [ANCHO-1:0] a1,
    input  logic [ANCHO-1:0] b1,
    output logic             listo1,
    output logic [ANCHO-1:0] res1,
    output logic             ocupado,
    output logic             enb,
    output logic [1:0]       modo,
    output logic [ANCHO-1:0] a,
    output logic [ANCHO-1:0] b,
    input  logic [ANCHO-1:0] c
);

    localparam logic [3:0] CNT_INI = 4'(LATENCIA - 1);

    estado_t          r_estado, w_estado_sig;
    logic             r_sel, r_ultimo;
    logic [1:0]       r_modo_sel;
    logic [ANCHO-1:0] r_a_sel, r_b_sel;
    logic [3:0]       r_cnt;
    logic [ANCHO-1:0] r_res0, r_res1;
    logic             w_gnt_valid, w_gnt_sel;
    logic             w_activo;

    arbitro_rr u_arbitro (
        .req0      (req0),
        .req1      (req1),
        .ultimo    (r_ultimo),
        .gnt_valid (w_gnt_valid),
        .gnt_sel   (w_gnt_sel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_estado <= REPOSO;
        else      r_estado <= w_estado_sig;
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO:  if (w_gnt_valid) w_estado_sig = EMITIR;
            EMITIR:  w_estado_sig = ESPERA;
            ESPERA:  if (r_cnt == 4'd0) w_estado_sig = ENTREGA;
            ENTREGA: w_estado_sig = REPOSO;
            default: w_estado_sig = REPOSO;
        endcase
    end

    // Operands are frozen at the grant so the requester may change them freely afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel      <= 1'b0;
            r_ultimo   <= 1'b1;
            r_modo_sel <= '0;
            r_a_sel    <= '0;
            r_b_sel    <= '0;
            r_cnt      <= '0;
            r_res0     <= '0;
            r_res1     <= '0;
        end else begin
            case (r_estado)
                REPOSO: if (w_gnt_valid) begin
                    r_sel      <= w_gnt_sel;
                    r_modo_sel <= w_gnt_sel ? modo1 : modo0;
                    r_a_sel    <= w_gnt_sel ? a1 : a0;
                    r_b_sel    <= w_gnt_sel ? b1 : b0;
                end
                EMITIR: r_cnt <= CNT_INI;
                ESPERA: begin
                    if (r_cnt == 4'd0) begin
                        if (r_sel) r_res1 <= c;
                        else       r_res0 <= c;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ENTREGA: r_ultimo <= r_sel;
                default: ;
            endcase
        end
    end

    assign w_activo = (r_estado == EMITIR) || (r_estado == ESPERA);
    assign enb      = (r_estado == EMITIR);
    assign modo     = w_activo ? r_modo_sel : 2'b00;
    assign a        = w_activo ? r_a_sel : '0;
    assign b        = w_activo ? r_b_sel : '0;
    assign ocupado  = (r_estado != REPOSO);
    assign listo0   = (r_estado == ENTREGA) && !r_sel;
    assign listo1   = (r_estado == ENTREGA) && r_sel;
    assign res0     = r_res0;
    assign res1     = r_res1;

endmodule

// File: tb/tb_calculadora_arbitro.sv
// Drives a LATENCIA=1 and a LATENCIA=4 arbiter with identical stimulus and
// compares both against a timeline model of grants and deliveries.
module tb_calculadora_arbitro;
    import calculadora_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0, req1;
    logic [1:0]   modo0, modo1;
    logic [W-1:0] a0, b0, a1, b1;

    logic [1:0]        listo0_o, listo1_o, ocupado_o, enb_o;
    logic [1:0][1:0]   modo_o;
    logic [1:0][W-1:0] res0_o, res1_o, a_o, b_o, c_o;

    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] calc(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
        case (m)
            MODO_SUMA:  return x + y;
            MODO_RESTA: return x - y;
            MODO_AND:   return x & y;
            default:    return x | y;
        endcase
    endfunction

    calculadora_arbitro #(.ANCHO(W), .LATENCIA(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0(req0), .modo0(modo0), .a0(a0), .b0(b0), .listo0(listo0_o[0]), .res0(res0_o[0]),
        .req1(req1), .modo1(modo1), .a1(a1), .b1(b1), .listo1(listo1_o[0]), .res1(res1_o[0]),
        .ocupado(ocupado_o[0]), .enb(enb_o[0]), .modo(modo_o[0]), .a(a_o[0]), .b(b_o[0]), .c(c_o[0])
    );

    calculadora_arbitro #(.ANCHO(W), .LATENCIA(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .modo0(modo0), .a0(a0), .b0(b0), .listo0(listo0_o[1]), .res0(res0_o[1]),
        .req1(req1), .modo1(modo1), .a1(a1), .b1(b1), .listo1(listo1_o[1]), .res1(res1_o[1]),
        .ocupado(ocupado_o[1]), .enb(enb_o[1]), .modo(modo_o[1]), .a(a_o[1]), .b(b_o[1]), .c(c_o[1])
    );

    // Stub calculators: c valid LATENCIA edges after the enb cycle.
    logic [W-1:0]      pipe1;
    logic [3:0][W-1:0] pipe4;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe1 <= '0;
            pipe4 <= '0;
        end else begin
            if (enb_o[0]) pipe1 <= calc(modo_o[0], a_o[0], b_o[0]);
            pipe4 <= {pipe4[2:0], enb_o[1] ? calc(modo_o[1], a_o[1], b_o[1]) : pipe4[0]};
        end
    end
    assign c_o[0] = pipe1;
    assign c_o[1] = pipe4[3];

    // Model: t counts cycles since the grant edge (1 = enb cycle, 2+lat = delivery cycle).
    int           lat [2] = '{1, 4};
    bit           busy [2];
    int           t [2];
    bit           msel [2];
    bit           mult [2];
    logic [1:0]   mm [2];
    logic [W-1:0] ma [2], mb [2];
    logic [W-1:0] mres [2][2];

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, d, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; t[d] = 0; msel[d] = 1'b0; mult[d] = 1'b1;
            mm[d] = '0; ma[d] = '0; mb[d] = '0;
            mres[d][0] = '0; mres[d][1] = '0;
        end
    endtask

    task automatic check_outputs();
        bit emit, act, ent;
        for (int d = 0; d < 2; d++) begin
            emit = busy[d] && t[d] == 1;
            act  = busy[d] && t[d] >= 1 && t[d] <= 1 + lat[d];
            ent  = busy[d] && t[d] == 2 + lat[d];
            chk("ocupado", d, 32'(ocupado_o[d]), 32'(busy[d]));
            chk("enb",     d, 32'(enb_o[d]),     32'(emit));
            chk("modo",    d, 32'(modo_o[d]),    act ? 32'(mm[d]) : 32'd0);
            chk("a",       d, 32'(a_o[d]),       act ? 32'(ma[d]) : 32'd0);
            chk("b",       d, 32'(b_o[d]),       act ? 32'(mb[d]) : 32'd0);
            chk("listo0",  d, 32'(listo0_o[d]),  32'(ent && !msel[d]));
            chk("listo1",  d, 32'(listo1_o[d]),  32'(ent && msel[d]));
            chk("res0",    d, 32'(res0_o[d]),    32'(mres[d][0]));
            chk("res1",    d, 32'(res1_o[d]),    32'(mres[d][1]));
        end
    endtask

    // Check the current cycle, advance the model across the coming edge, then step the clock.
    task automatic cycle();
        check_outputs();
        for (int d = 0; d < 2; d++) begin
            if (!busy[d]) begin
                if (req0 || req1) begin
                    busy[d] = 1'b1;
                    t[d]    = 1;
                    msel[d] = (req0 && req1) ? !mult[d] : req1;
                    mm[d]   = msel[d] ? modo1 : modo0;
                    ma[d]   = msel[d] ? a1 : a0;
                    mb[d]   = msel[d] ? b1 : b0;
                end
            end else if (t[d] == 1 + lat[d]) begin
                mres[d][msel[d]] = calc(mm[d], ma[d], mb[d]);
                t[d]++;
            end else if (t[d] == 2 + lat[d]) begin
                busy[d] = 1'b0;
                mult[d] = msel[d];
            end else begin
                t[d]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        modo0 = '0; modo1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single request from requester 0, dropped early (must still complete).
        req0 = 1'b1; modo0 = MODO_SUMA; a0 = 8'd5; b0 = 8'd3;
        cycle();
        req0 = 1'b0;
        repeat (9) cycle();
        chk("single_res0", 0, 32'(res0_o[0]), 32'd8);
        chk("single_res0", 1, 32'(res0_o[1]), 32'd8);

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        req0 = 1'b1; modo0 = MODO_RESTA; a0 = 8'd10; b0 = 8'd4;
        req1 = 1'b1; modo1 = MODO_SUMA;  a1 = 8'd2;  b1 = 8'd2;
        repeat (8) cycle();
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) cycle();
        chk("tie_res0", 0, 32'(res0_o[0]), 32'd6);
        chk("tie_res1", 0, 32'(res1_o[0]), 32'd4);
        chk("tie_res1", 1, 32'(res1_o[1]), 32'd4);

        // Continuous contention: grants alternate.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a0 = 8'(i); b0 = 8'd1; a1 = 8'(100 + i); b1 = 8'd2;
            cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) cycle();

        // Operand change while in flight.
        req0 = 1'b1; modo0 = MODO_SUMA; a0 = 8'd5; b0 = 8'd3;
        cycle();
        req0 = 1'b0;
        cycle();
        a0 = 8'd200;
        repeat (8) cycle();
        chk("inflight_res0", 0, 32'(res0_o[0]), 32'd8);
        chk("inflight_res0", 1, 32'(res0_o[1]), 32'd8);

        // Reset during the wait phase, then a normal request from requester 1.
        req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
        cycle();
        req0 = 1'b0;
        cycle();
        do_reset();
        cycle();
        req1 = 1'b1; modo1 = MODO_SUMA; a1 = 8'd1; b1 = 8'd1;
        cycle();
        req1 = 1'b0;
        repeat (8) cycle();
        chk("post_rst_res1", 0, 32'(res1_o[0]), 32'd2);
        chk("post_rst_res1", 1, 32'(res1_o[1]), 32'd2);
        chk("post_rst_res0", 1, 32'(res0_o[1]), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            modo0 = 2'($urandom_range(0, 3));
            modo1 = 2'($urandom_range(0, 3));
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            if ($urandom_range(0, 149) == 0) do_reset();
            else cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
